// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the iCache/dCache memory arbiter.
package mem_arbiter_pkg;

    localparam int MEM_ADDRESS_LEN   = 28;
    localparam int ICACHE_LINE_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } requester_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin decision: a lone requester wins, a tie goes to the
// requester that was not granted last. grant[0] selects I, grant[1] selects D.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       req_icache,
    input  logic       req_dcache,
    input  requester_e last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req_icache && req_dcache) begin
            grant = (last_grant == GRANT_D) ? 2'b01 : 2'b10;
        end else if (req_icache) begin
            grant = 2'b01;
        end else if (req_dcache) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates iCache fills and dCache fills/write-backs onto a single memory
// port, one transaction outstanding at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDRESS_LEN,
    parameter int LINE_W = ICACHE_LINE_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqI,
    input  logic [ADDR_W-1:0] reqAddrI,
    input  logic              reqD,
    input  logic              reqWrD,
    input  logic [ADDR_W-1:0] reqAddrD,
    input  logic [LINE_W-1:0] wrDataD,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic [LINE_W-1:0] dataI,
    output logic              rdyI,
    output logic [LINE_W-1:0] dataD,
    output logic              rdyD
);

    arb_state_e        state_q, state_d;
    requester_e        owner_q, owner_d;
    requester_e        last_grant_q, last_grant_d;
    logic              just_done_q, just_done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] data_i_q, data_i_d;
    logic [LINE_W-1:0] data_d_q, data_d_d;

    logic              req_i_eff;
    logic              req_d_eff;
    logic [1:0]        grant;

    // A requester may still hold req in the idle cycle right after its rdy
    // pulse; mask it there so the finished transaction is not issued twice.
    assign req_i_eff = reqI && !(just_done_q && owner_q == GRANT_I);
    assign req_d_eff = reqD && !(just_done_q && owner_q == GRANT_D);

    rr_arb2 u_rr_arb2 (
        .req_icache (req_i_eff),
        .req_dcache (req_d_eff),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        just_done_d  = 1'b0;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        data_i_d     = data_i_q;
        data_d_d     = data_d_q;

        case (state_q)
            IDLE: begin
                if (grant[1]) begin
                    state_d = BUSY;
                    owner_d = GRANT_D;
                    addr_d  = reqAddrD;
                    we_d    = reqWrD;
                    wdata_d = wrDataD;
                end else if (grant[0]) begin
                    state_d = BUSY;
                    owner_d = GRANT_I;
                    addr_d  = reqAddrI;
                    we_d    = 1'b0;
                    wdata_d = '0;
                end
            end
            BUSY: begin
                if (mem_rdy) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (owner_q == GRANT_D) begin
                            data_d_d = mem_rdata;
                        end else begin
                            data_i_d = mem_rdata;
                        end
                    end
                end
            end
            RESP: begin
                state_d      = IDLE;
                last_grant_d = owner_q;
                just_done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= GRANT_I;
            last_grant_q <= GRANT_D;
            just_done_q  <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            data_i_q     <= '0;
            data_d_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            just_done_q  <= just_done_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            data_i_q     <= data_i_d;
            data_d_q     <= data_d_d;
        end
    end

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign dataI     = data_i_q;
    assign dataD     = data_d_q;
    assign rdyI      = (state_q == RESP) && (owner_q == GRANT_I);
    assign rdyD      = (state_q == RESP) && (owner_q == GRANT_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a queue of expected transactions is filled
// as requests are raised and drained as the memory model completes them.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          reqI;
    logic [AW-1:0] reqAddrI;
    logic          reqD;
    logic          reqWrD;
    logic [AW-1:0] reqAddrD;
    logic [LW-1:0] wrDataD;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_rdy;
    logic [LW-1:0] dataI;
    logic          rdyI;
    logic [LW-1:0] dataD;
    logic          rdyD;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .reqI      (reqI),
        .reqAddrI  (reqAddrI),
        .reqD      (reqD),
        .reqWrD    (reqWrD),
        .reqAddrD  (reqAddrD),
        .wrDataD   (wrDataD),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .dataI     (dataI),
        .rdyI      (rdyI),
        .dataD     (dataD),
        .rdyD      (rdyD)
    );

    typedef struct {
        logic          is_d;
        logic [AW-1:0] addr;
        logic          we;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        logic [LW-1:0] exp_line;
    } txn_t;

    txn_t          sb[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [LW-1:0] model_i  = '0;
    logic [LW-1:0] model_d  = '0;

    task automatic check_output(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic apply_stimulus(input logic ri, input logic [AW-1:0] ai, input logic rd,
                                  input logic wr, input logic [AW-1:0] ad, input logic [LW-1:0] wd);
        reqI     = ri;
        reqAddrI = ai;
        reqD     = rd;
        reqWrD   = wr;
        reqAddrD = ad;
        wrDataD  = wd;
    endtask

    // Expected transactions are queued in the order they must be served.
    task automatic push_txn(input logic is_d, input logic [AW-1:0] addr, input logic we,
                            input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
        txn_t t;
        if (!we) begin
            if (is_d) model_d = rdata;
            else      model_i = rdata;
        end
        t.is_d     = is_d;
        t.addr     = addr;
        t.we       = we;
        t.wdata    = wdata;
        t.rdata    = rdata;
        t.exp_line = is_d ? model_d : model_i;
        sb.push_back(t);
    endtask

    // Memory model: waits for a grant, holds it for 'latency' cycles, then
    // completes it and checks the response against the queue head.
    task automatic serve_mem(input int latency, input bit perturb);
        txn_t t;
        int   waited = 0;
        int   high   = 0;
        bit   stable = 1'b1;
        while (mem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (mem_req !== 1'b1) begin
            check_output("grant_timeout", mem_req, 1);
            if (sb.size() > 0) t = sb.pop_front();
            return;
        end
        if (sb.size() == 0) begin
            check_output("unexpected_grant", 0, 1);
            return;
        end
        t = sb.pop_front();
        check_output("grant_addr", mem_addr, t.addr);
        check_output("grant_we", mem_we, t.we);
        check_output("grant_wdata", mem_wdata, t.wdata);
        for (int c = 1; c <= latency; c++) begin
            if (mem_req === 1'b1) high++;
            if (mem_addr !== t.addr || mem_we !== t.we || mem_wdata !== t.wdata) stable = 1'b0;
            if (perturb && c == 2) begin
                reqAddrI = ~reqAddrI;
                reqAddrD = ~reqAddrD;
                wrDataD  = ~wrDataD;
            end
            if (c == latency) begin
                mem_rdy   = 1'b1;
                mem_rdata = t.rdata;
            end
            @(negedge clk);
        end
        mem_rdy   = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        check_output("busy_cycles", high, latency);
        check_output("busy_stable", stable, 1);
        check_output("resp_mem_req", mem_req, 0);
        check_output("resp_rdyI", rdyI, !t.is_d);
        check_output("resp_rdyD", rdyD, t.is_d);
        if (t.is_d) check_output("resp_dataD", dataD, t.exp_line);
        else        check_output("resp_dataI", dataI, t.exp_line);
        @(negedge clk);
        check_output("rdy_one_shot", {rdyI, rdyD}, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        reset     = 1'b1;
        mem_rdy   = 1'b0;
        mem_rdata = '0;
        apply_stimulus(0, '0, 0, 0, '0, '0);
        repeat (3) @(negedge clk);
        check_output("rst_mem_req", mem_req, 0);
        check_output("rst_mem_we", mem_we, 0);
        check_output("rst_mem_addr", mem_addr, 0);
        check_output("rst_mem_wdata", mem_wdata, 0);
        check_output("rst_rdyI", rdyI, 0);
        check_output("rst_rdyD", rdyD, 0);
        check_output("rst_dataI", dataI, 0);
        check_output("rst_dataD", dataD, 0);
        reset = 1'b0;

        $display("[TB] iCache fill, 5-cycle memory latency");
        push_txn(0, 28'h0000001, 0, '0, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
        apply_stimulus(1, 28'h0000001, 0, 0, '0, '0);
        serve_mem(5, 0);
        @(negedge clk);
        check_output("no_regrant", mem_req, 0);
        apply_stimulus(0, '0, 0, 0, '0, '0);

        $display("[TB] iCache address changes while busy");
        push_txn(0, 28'h0000100, 0, '0, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        apply_stimulus(1, 28'h0000100, 0, 0, '0, '0);
        serve_mem(4, 1);
        apply_stimulus(0, '0, 0, 0, '0, '0);

        $display("[TB] dCache write-back");
        push_txn(1, 28'h0000020, 1, 128'h12345678_9ABCDEF0_12345678_9ABCDEF0,
                 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
        apply_stimulus(0, '0, 1, 1, 28'h0000020, 128'h12345678_9ABCDEF0_12345678_9ABCDEF0);
        serve_mem(3, 0);
        apply_stimulus(0, '0, 0, 0, '0, '0);

        $display("[TB] dCache fill");
        push_txn(1, 28'h0000040, 0, '0, 128'h55555555_66666666_77777777_88888888);
        apply_stimulus(0, '0, 1, 0, 28'h0000040, '0);
        serve_mem(2, 0);
        apply_stimulus(0, '0, 0, 0, '0, '0);

        $display("[TB] both requesters held: I, D, I, D");
        push_txn(0, 28'h0000080, 0, '0, 128'h11111111_11111111_11111111_11111111);
        push_txn(1, 28'h00000C0, 0, '0, 128'h22222222_22222222_22222222_22222222);
        push_txn(0, 28'h0000080, 0, '0, 128'h33333333_33333333_33333333_33333333);
        push_txn(1, 28'h00000C0, 0, '0, 128'h44444444_44444444_44444444_44444444);
        apply_stimulus(1, 28'h0000080, 1, 0, 28'h00000C0, '0);
        repeat (4) serve_mem(3, 0);
        apply_stimulus(0, '0, 0, 0, '0, '0);

        $display("[TB] stray mem_rdy while idle");
        @(negedge clk);
        mem_rdy   = 1'b1;
        mem_rdata = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;
        @(negedge clk);
        mem_rdy = 1'b0;
        check_output("stray_mem_req", mem_req, 0);
        check_output("stray_rdy", {rdyI, rdyD}, 0);
        check_output("stray_dataI", dataI, model_i);
        check_output("stray_dataD", dataD, model_d);
        @(negedge clk);
        check_output("stray_no_grant", mem_req, 0);

        // Leaves I as the last grant so the post-reset tie shows the reset value.
        push_txn(0, 28'h0000200, 0, '0, 128'h99999999_AAAAAAAA_99999999_AAAAAAAA);
        apply_stimulus(1, 28'h0000200, 0, 0, '0, '0);
        serve_mem(2, 0);
        apply_stimulus(0, '0, 0, 0, '0, '0);

        $display("[TB] reset in third busy cycle");
        apply_stimulus(1, 28'h0000300, 0, 0, '0, '0);
        w = 0;
        while (mem_req !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_output("abort_grant", mem_req, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        apply_stimulus(0, '0, 0, 0, '0, '0);
        @(negedge clk);
        reset   = 1'b0;
        model_i = '0;
        model_d = '0;
        mem_rdy   = 1'b1;
        mem_rdata = 128'hFEEDFACE_FEEDFACE_FEEDFACE_FEEDFACE;
        @(negedge clk);
        mem_rdy = 1'b0;
        check_output("abort_rdy", {rdyI, rdyD}, 0);
        check_output("abort_mem_req", mem_req, 0);
        check_output("abort_dataI", dataI, 0);
        @(negedge clk);
        check_output("abort_rdy_late", {rdyI, rdyD}, 0);

        $display("[TB] tie after reset goes to I");
        push_txn(0, 28'h0000007, 0, '0, 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D);
        push_txn(1, 28'h0000009, 0, '0, 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE);
        apply_stimulus(1, 28'h0000007, 1, 0, 28'h0000009, '0);
        serve_mem(3, 0);
        apply_stimulus(0, '0, 1, 0, 28'h0000009, '0);
        serve_mem(3, 0);
        apply_stimulus(0, '0, 0, 0, '0, '0);

        check_output("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
